// File: rtl/cbrt_pkg.sv
// Shared constants and state encoding for the cube-root unit.
package cbrt_pkg;

    localparam int unsigned OpWidth   = 8;
    localparam int unsigned ProdWidth = 16;

    // Bit-serial schedule: three result bits, one per 3-bit group of the operand.
    localparam int unsigned ShiftFirst = 6;
    localparam int unsigned ShiftStep  = 3;
    localparam int unsigned ShiftLast  = 0;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StShift    = 4'd1,
        StMulStart = 4'd2,
        StMulWait  = 4'd3,
        StCalc     = 4'd4,
        StCmp      = 4'd5,
        StNext     = 4'd6
    } state_e;

endpackage

// File: rtl/cbrt_mul.sv
// 8x8 unsigned sequential shift-add multiplier: one partial product per cycle.
module mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] y,
    output logic        busy
);

    logic [15:0] mcand_q;
    logic [7:0]  mplier_q;
    logic [15:0] acc_q;
    logic [3:0]  cnt_q;
    logic        busy_q;

    // Load operands on an accepted start, then shift-add for eight cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start && !busy_q) begin
            mcand_q  <= {8'h00, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= 4'd8;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 4'd1;
            // Last partial product lands on the same edge busy drops.
            if (cnt_q == 4'd1) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign y    = acc_q;
    assign busy = busy_q;

endmodule

// File: rtl/cbrt.sv
// Sequential floor(cbrt(x)) for an 8-bit operand, restoring bit-serial algorithm.
module cbrt
    import cbrt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  x_i,
    input  logic        start,
    output logic [2:0]  result,
    output logic        busy,
    output logic [3:0]  state_debug,
    output logic [3:0]  state_next_debug,
    output logic [15:0] buff_debug,
    output logic [15:0] buff_next_debug,
    output logic [15:0] x_debug,
    output logic [15:0] res_mul_debug
);

    state_e               state_q, state_d;
    logic [OpWidth-1:0]   y_q, y_d;
    logic [ProdWidth-1:0] x_q, x_d;
    logic [ProdWidth-1:0] buff_q, buff_d;
    logic [2:0]           s_q, s_d;
    logic [2:0]           result_q, result_d;
    logic                 mul_start;
    logic                 mul_busy;
    logic [ProdWidth-1:0] mul_y;

    mul u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (y_q),
        .b     (y_q + 8'd1),
        .y     (mul_y),
        .busy  (mul_busy)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: accumulator, remainder, trial value, shift, result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_q      <= '0;
            x_q      <= '0;
            buff_q   <= '0;
            s_q      <= '0;
            result_q <= '0;
        end else begin
            y_q      <= y_d;
            x_q      <= x_d;
            buff_q   <= buff_d;
            s_q      <= s_d;
            result_q <= result_d;
        end
    end

    // Next-state and datapath next values; every step runs, no early exit.
    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        x_d       = x_q;
        buff_d    = buff_q;
        s_d       = s_q;
        result_d  = result_q;
        mul_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d     = {8'h00, x_i};
                    y_d     = '0;
                    s_d     = 3'(ShiftFirst);
                    state_d = StShift;
                end
            end
            StShift: begin
                y_d     = y_q << 1;
                state_d = StMulStart;
            end
            StMulStart: begin
                mul_start = 1'b1;
                state_d   = StMulWait;
            end
            StMulWait: begin
                if (!mul_busy) begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // b = (3p + 1) << s using only shifts and adds.
                buff_d  = ((mul_y << 1) + mul_y + 16'd1) << s_q;
                state_d = StCmp;
            end
            StCmp: begin
                if (x_q >= buff_q) begin
                    x_d = x_q - buff_q;
                    y_d = y_q + 8'd1;
                end
                state_d = StNext;
            end
            StNext: begin
                if (s_q == 3'(ShiftLast)) begin
                    result_d = y_q[2:0];
                    state_d  = StIdle;
                end else begin
                    s_d     = s_q - 3'(ShiftStep);
                    state_d = StShift;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign result           = result_q;
    assign busy             = (state_q != StIdle);
    assign state_debug      = state_q;
    assign state_next_debug = state_d;
    assign buff_debug       = buff_q;
    assign buff_next_debug  = buff_d;
    assign x_debug          = x_q;
    assign res_mul_debug    = mul_y;

endmodule

// File: tb/tb_cbrt.sv
// Directed self-checking bench for the cube-root unit.
module tb_cbrt;

    logic        clk;
    logic        rst;
    logic [7:0]  x_i;
    logic        start;
    logic [2:0]  result;
    logic        busy;
    logic [3:0]  state_debug;
    logic [3:0]  state_next_debug;
    logic [15:0] buff_debug;
    logic [15:0] buff_next_debug;
    logic [15:0] x_debug;
    logic [15:0] res_mul_debug;

    int checks = 0;
    int errors = 0;
    int ref_cycles = -1;

    cbrt dut (
        .clk              (clk),
        .rst              (rst),
        .x_i              (x_i),
        .start            (start),
        .result           (result),
        .busy             (busy),
        .state_debug      (state_debug),
        .state_next_debug (state_next_debug),
        .buff_debug       (buff_debug),
        .buff_next_debug  (buff_next_debug),
        .x_debug          (x_debug),
        .res_mul_debug    (res_mul_debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cbrt_ref(input int x);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    // Start one run and wait (bounded) for busy to fall; cyc counts edges after accept.
    task automatic run_op(input logic [7:0] x, output logic [2:0] res, output int cyc);
        @(negedge clk);
        x_i   = x;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        res = result;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        x_i   = 8'd0;
        #12;
        checks++;
        if (busy !== 1'b0 || result !== 3'd0 || state_debug !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b result=%0d state=%0d, want 0/0/0",
                     busy, result, state_debug);
        end
        checks++;
        if (buff_debug !== 16'd0 || x_debug !== 16'd0 || res_mul_debug !== 16'd0) begin
            errors++;
            $display("FAIL reset_debug: buff=%0d x=%0d mul=%0d, want 0/0/0",
                     buff_debug, x_debug, res_mul_debug);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_cubes();
        logic [7:0] xs [5] = '{8'd27, 8'd64, 8'd125, 8'd216, 8'd8};
        int         ex [5] = '{3, 4, 5, 6, 2};
        logic [2:0] r;
        int         cyc;
        for (int i = 0; i < 5; i++) begin
            reset_pulse();
            run_op(xs[i], r, cyc);
            checks++;
            if (r !== 3'(ex[i])) begin
                errors++;
                $display("FAIL cube x=%0d: got %0d want %0d", xs[i], r, ex[i]);
            end
            if (ref_cycles < 0) ref_cycles = cyc;
            checks++;
            if (cyc < 1 || cyc > 45 || cyc != ref_cycles) begin
                errors++;
                $display("FAIL cube_latency x=%0d: got %0d cycles want %0d (<=45)",
                         xs[i], cyc, ref_cycles);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] xs [6] = '{8'd0, 8'd1, 8'd7, 8'd26, 8'd63, 8'd255};
        int         ex [6] = '{0, 1, 1, 2, 3, 6};
        logic [2:0] r;
        int         cyc;
        for (int i = 0; i < 6; i++) begin
            run_op(xs[i], r, cyc);
            checks++;
            if (r !== 3'(ex[i])) begin
                errors++;
                $display("FAIL boundary x=%0d: got %0d want %0d", xs[i], r, ex[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [2:0] r;
        int         cyc;
        int         bad_val = 0;
        int         bad_cyc = 0;
        for (int x = 0; x < 256; x++) begin
            run_op(8'(x), r, cyc);
            checks++;
            if (r !== 3'(cbrt_ref(x))) begin
                errors++;
                bad_val++;
                if (bad_val < 5)
                    $display("FAIL exhaustive x=%0d: got %0d want %0d", x, r, cbrt_ref(x));
            end
            checks++;
            if (cyc != ref_cycles) begin
                errors++;
                bad_cyc++;
                if (bad_cyc < 5)
                    $display("FAIL exhaustive_latency x=%0d: got %0d want %0d",
                             x, cyc, ref_cycles);
            end
        end
    endtask

    task automatic test_handshake();
        int cyc;
        // busy and SHIFT state one edge after acceptance.
        @(negedge clk);
        x_i   = 8'd125;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || state_debug !== 4'd1) begin
            errors++;
            $display("FAIL accept_edge: busy=%b state=%0d want 1/1", busy, state_debug);
        end
        // Mid-run start with a new operand, plus operand churn, must be ignored.
        repeat (10) @(negedge clk);
        x_i   = 8'd27;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x_i   = 8'd255;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (result !== 3'd5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_midrun_start: result=%0d busy=%b want 5/0", result, busy);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (result !== 3'd5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL result_hold: result=%0d busy=%b want 5/0", result, busy);
        end
        // Held-high start restarts right after completion.
        x_i   = 8'd64;
        start = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (result !== 3'd4) begin
            errors++;
            $display("FAIL held_start_first: result=%0d want 4", result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL held_start_restart: busy=%b want 1", busy);
        end
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (busy !== 1'b0 || result !== 3'd4) begin
            errors++;
            $display("FAIL held_start_second: busy=%b result=%0d want 0/4", busy, result);
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] r;
        int         cyc;
        @(negedge clk);
        x_i   = 8'd125;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || result !== 3'd0 || state_debug !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%b result=%0d state=%0d want 0/0/0",
                     busy, result, state_debug);
        end
        @(negedge clk);
        rst = 1'b1;
        run_op(8'd125, r, cyc);
        checks++;
        if (r !== 3'd5 || cyc != ref_cycles) begin
            errors++;
            $display("FAIL after_reset: result=%0d cycles=%0d want 5/%0d", r, cyc, ref_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_cubes();
        test_boundaries();
        test_exhaustive();
        test_handshake();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
